// File: rtl/freq_meter.sv
// freq_meter: frequency / period / duty-cycle meter over a fixed gate window.
// Optional reciprocal-frequency path: define FREQ_METER_RECIP_EN.
// One restoring divider is shared by the duty and reciprocal computations.
module freq_meter #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GATE_DIV    = 1,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned FREQ_W      = 28,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOW_THRESH  = 1000
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              sign_in,
  output logic [FREQ_W-1:0] freq,
  output logic [CNT_W-1:0]  period,
  output logic [6:0]        duty,
  output logic              mode,
  output logic              no_signal,
  output logic              valid
);

  localparam int unsigned GATE_CYCLES = CLK_HZ / GATE_DIV;
  localparam int unsigned DIV_W       = CNT_W + 7;
  localparam int unsigned DC_W        = $clog2(DIV_W + 1);
  localparam int unsigned XW          = DIV_W + FREQ_W + 32;
  localparam logic [XW-1:0] FREQ_MAX  = {{(XW-FREQ_W){1'b0}}, {FREQ_W{1'b1}}};

`ifdef FREQ_METER_RECIP_EN
  typedef enum logic [1:0] {IDLE, DIV_DUTY, DIV_FREQ, PUBLISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV_DUTY, PUBLISH} state_t;
`endif

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced, synced_d, rise;

  logic [CNT_W-1:0] gate_cnt;
  logic             gate_end;

  logic [CNT_W-1:0] edge_cnt, edge_nxt, high_cnt, high_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt, period_last, plast_nxt;
  logic             period_sat, psat_nxt;
  logic [1:0]       seen, seen_nxt;
  logic             pok_nxt;

  logic [CNT_W-1:0] edge_snap, period_snap;
  logic             pok_snap;

  logic [DIV_W-1:0] rem, quo, dvs, rem_step, quo_step;
  logic [DIV_W:0]   shifted, diff;
  logic             ge;
  logic [DC_W-1:0]  div_cnt;
  logic [6:0]       duty_res;

  logic load_duty, step, duty_done, pub;
`ifdef FREQ_METER_RECIP_EN
  logic             load_freq, use_recip;
  logic [XW-1:0]    recip_ext;
  logic [FREQ_W-1:0] recip_sat;
`endif

  logic [XW-1:0]     direct_ext;
  logic [FREQ_W-1:0] direct_sat, freq_sel;
  logic              mode_sel;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~synced_d;
  assign gate_end = (gate_cnt == CNT_W'(GATE_CYCLES - 1));

  // Synchroniser chain plus one-cycle history of the synced signal
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      synced_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sign_in};
      synced_d <= synced;
    end
  end

  // Free-running gate counter, wraps back-to-back
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst)          gate_cnt <= '0;
    else if (gate_end) gate_cnt <= '0;
    else               gate_cnt <= gate_cnt + 1'b1;
  end

  // Next values of accumulators and period tracking, including this cycle's sample
  always_comb begin
    edge_nxt = edge_cnt;
    if (rise && (edge_cnt != '1)) edge_nxt = edge_cnt + 1'b1;
    high_nxt  = high_cnt + CNT_W'(synced);
    pcnt_nxt  = (pcnt == '1) ? pcnt : pcnt + 1'b1;
    plast_nxt = period_last;
    psat_nxt  = period_sat | (pcnt_nxt == '1);
    seen_nxt  = seen;
    if (rise) begin
      plast_nxt = pcnt_nxt;
      pcnt_nxt  = '0;
      psat_nxt  = 1'b0;
      if (seen != 2'd2) seen_nxt = seen + 1'b1;
    end
    pok_nxt = (seen_nxt == 2'd2) && !psat_nxt;
  end

  // Accumulators, period counter and window-end snapshots
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      edge_cnt    <= '0;
      high_cnt    <= '0;
      pcnt        <= '0;
      period_last <= '0;
      period_sat  <= 1'b0;
      seen        <= '0;
      edge_snap   <= '0;
      period_snap <= '0;
      pok_snap    <= 1'b0;
    end else begin
      pcnt        <= pcnt_nxt;
      period_last <= plast_nxt;
      period_sat  <= psat_nxt;
      seen        <= seen_nxt;
      if (gate_end) begin
        edge_cnt    <= '0;
        high_cnt    <= '0;
        edge_snap   <= edge_nxt;
        period_snap <= plast_nxt;
        pok_snap    <= pok_nxt;
      end else begin
        edge_cnt <= edge_nxt;
        high_cnt <= high_nxt;
      end
    end
  end

  // One restoring-division step; borrow bit of diff selects the quotient bit
  always_comb begin
    shifted  = {rem, quo[DIV_W-1]};
    diff     = shifted - {1'b0, dvs};
    ge       = ~diff[DIV_W];
    rem_step = ge ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
    quo_step = {quo[DIV_W-2:0], ge};
  end

  // Frequency selection from snapshots and divider quotient
  always_comb begin
    direct_ext = XW'(edge_snap) * XW'(GATE_DIV);
    direct_sat = (direct_ext > FREQ_MAX) ? '1 : direct_ext[FREQ_W-1:0];
`ifdef FREQ_METER_RECIP_EN
    recip_ext = XW'(quo);
    recip_sat = (recip_ext > FREQ_MAX) ? '1 : recip_ext[FREQ_W-1:0];
    use_recip = (direct_ext < XW'(LOW_THRESH)) && pok_snap;
    freq_sel  = use_recip ? recip_sat : direct_sat;
    mode_sel  = use_recip;
`else
    freq_sel  = direct_sat;
    mode_sel  = 1'b0;
`endif
    if (edge_snap == '0) freq_sel = '0;
  end

  // Sequencer state register
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Sequencer next state and divider controls
  always_comb begin
    state_nxt = state;
    load_duty = 1'b0;
    step      = 1'b0;
    duty_done = 1'b0;
    pub       = 1'b0;
`ifdef FREQ_METER_RECIP_EN
    load_freq = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (gate_end) begin
          load_duty = 1'b1;
          state_nxt = DIV_DUTY;
        end
      end
      DIV_DUTY: begin
        step = 1'b1;
        if (div_cnt == DC_W'(DIV_W - 1)) begin
          duty_done = 1'b1;
`ifdef FREQ_METER_RECIP_EN
          state_nxt = use_recip ? DIV_FREQ : PUBLISH;
`else
          state_nxt = PUBLISH;
`endif
        end
      end
`ifdef FREQ_METER_RECIP_EN
      // First cycle loads operands, then DIV_W steps
      DIV_FREQ: begin
        if (div_cnt == '0) load_freq = 1'b1;
        else               step      = 1'b1;
        if (div_cnt == DC_W'(DIV_W)) state_nxt = PUBLISH;
      end
`endif
      PUBLISH: begin
        pub       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared divider datapath; duty operands come from the live count so the
  // closing cycle's sample is included without an extra snapshot cycle
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      div_cnt  <= '0;
      duty_res <= '0;
    end else begin
      div_cnt <= ((state_nxt == state) && (state != IDLE)) ? div_cnt + 1'b1 : '0;
      if (load_duty) begin
        rem <= '0;
        quo <= DIV_W'(high_nxt) * DIV_W'(100);
        dvs <= DIV_W'(GATE_CYCLES);
      end
`ifdef FREQ_METER_RECIP_EN
      else if (load_freq) begin
        rem <= '0;
        quo <= DIV_W'(CLK_HZ);
        dvs <= DIV_W'(period_snap);
      end
`endif
      else if (step) begin
        rem <= rem_step;
        quo <= quo_step;
      end
      if (duty_done) duty_res <= (quo_step > DIV_W'(100)) ? 7'd100 : quo_step[6:0];
    end
  end

  // Published outputs, updated together with a one-cycle valid pulse
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      freq      <= '0;
      period    <= '0;
      duty      <= '0;
      mode      <= 1'b0;
      no_signal <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= pub;
      if (pub) begin
        freq      <= freq_sel;
        period    <= period_snap;
        duty      <= duty_res;
        mode      <= mode_sel;
        no_signal <= (edge_snap == '0) | ~pok_snap;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter (CLK_HZ=10000, CNT_W=16).
// Expected results are queued per gate window; a monitor checks each valid.
module tb_freq_meter;

  localparam int unsigned G  = 10000;
  localparam int unsigned LD = 25;   // DIV_W+2, DIV_W=23
`ifdef FREQ_METER_RECIP_EN
  localparam bit          RECIP = 1'b1;
  localparam int unsigned LR    = 49; // 2*DIV_W+3
`else
  localparam bit          RECIP = 1'b0;
  localparam int unsigned LR    = 25;
`endif

  typedef struct {
    int unsigned idx;
    int unsigned at;
    logic [31:0] freq;
    logic [31:0] period;
    logic [31:0] duty;
    logic [31:0] mode;
    logic [31:0] nos;
  } exp_t;

  exp_t sbq[$];

  logic        clk_100M = 1'b0;
  logic        rst      = 1'b0;
  logic        sign_in  = 1'b0;
  logic [27:0] freq;
  logic [15:0] period;
  logic [6:0]  duty;
  logic        mode, no_signal, valid;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned m     = 0;
  bit          post  = 1'b0;

  freq_meter #(
    .CLK_HZ(10000), .GATE_DIV(1), .CNT_W(16), .FREQ_W(28),
    .SYNC_STAGES(2), .LOW_THRESH(100)
  ) dut (
    .clk_100M(clk_100M), .rst(rst), .sign_in(sign_in),
    .freq(freq), .period(period), .duty(duty),
    .mode(mode), .no_signal(no_signal), .valid(valid)
  );

  always #5 clk_100M = ~clk_100M;

  // Cycles since reset release; gate counter equals m mod G
  always @(posedge clk_100M) begin
    if (!rst) m <= 0;
    else      m <= m + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int unsigned idx, input int unsigned at, input int unsigned f,
                      input int unsigned p, input int unsigned d, input bit md, input bit ns);
    exp_t e;
    e.idx = idx; e.at = at; e.freq = f; e.period = p; e.duty = d;
    e.mode = {31'd0, md}; e.nos = {31'd0, ns};
    sbq.push_back(e);
  endtask

  // Signal as seen by the DUT after synchronisation, indexed by window cycle
  function automatic logic pat(input int unsigned mm, input bit ph);
    int unsigned q;
    if (!ph)        return (mm % 20) >= 10;
    if (mm < G)     return (mm % 400) >= 300;
    if (mm < 2*G)   return 1'b1;
    if (mm < 3*G)   return 1'b0;
    q = (mm - 3*G) % 10001;
    return (q >= 1) && (q <= 5000);
  endfunction

  // Drive two cycles ahead to compensate the synchroniser depth
  initial forever begin
    @(negedge clk_100M);
    sign_in = pat(m + 2, post);
  end

  // Monitor: every valid pops and checks one expected window result
  always @(negedge clk_100M) begin : monitor
    exp_t e;
    if (rst && valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=cycle %0d required=no valid", m);
      end else begin
        e = sbq.pop_front();
        check($sformatf("w%0d_cycle", e.idx), m, e.at);
        check($sformatf("w%0d_freq", e.idx), {4'd0, freq}, e.freq);
        check($sformatf("w%0d_period", e.idx), {16'd0, period}, e.period);
        check($sformatf("w%0d_duty", e.idx), {25'd0, duty}, e.duty);
        check($sformatf("w%0d_mode", e.idx), {31'd0, mode}, e.mode);
        check($sformatf("w%0d_no_signal", e.idx), {31'd0, no_signal}, e.nos);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Period 20, high 10: direct count
    push(0, G - 1 + LD, 500, 20, 50, 1'b0, 1'b0);
    repeat (3) @(negedge clk_100M);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_freq", {4'd0, freq}, 32'd0);
    rst = 1'b1;

    // Second window closes, then reset lands inside DIV_DUTY
    while (m != 2*G + 5) @(negedge clk_100M);
    check("pre_valid_seen", sbq.size(), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_freq", {4'd0, freq}, 32'd0);
    check("abort_period", {16'd0, period}, 32'd0);
    check("abort_duty", {25'd0, duty}, 32'd0);
    check("abort_mode", {31'd0, mode}, 32'd0);
    check("abort_no_signal", {31'd0, no_signal}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    repeat (3) @(negedge clk_100M);

    post = 1'b1;
    // Period 400, high 100: 25 edges, reciprocal 10000/400
    push(1, 1*G - 1 + LR, 25, 400, 25, RECIP, 1'b0);
    // Held high (no new edge): duty 100, no signal
    push(2, 2*G - 1 + LR, 0, 400, 100, RECIP, 1'b1);
    // Held low: duty 0, no signal
    push(3, 3*G - 1 + LR, 0, 400, 0, RECIP, 1'b1);
    // Period 10001: first edge after long gap, then steady period
    push(4, 4*G - 1 + LR, RECIP ? 0 : 1, 20101, 50, RECIP, 1'b0);
    push(5, 5*G - 1 + LR, RECIP ? 0 : 1, 10001, 50, RECIP, 1'b0);
    rst = 1'b1;

    while (m != 5*G + 200) @(negedge clk_100M);
    check("all_valids_seen", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
